serial_xfer_ctrl: RTL and testbench

Sequencing controller for a serial register-to-register transfer. It owns two load/shift registers, source and destination. It loads the source in parallel, then issues exactly WIDTH shift pulses so the source contents stream MSB-first into the destination over a 1-bit link. It is the control layer that sits above the team's load/shift register datapath and replaces hand-driven shift enables with a counted, handshaken transfer.

---
 rtl/serial_xfer_pkg.sv | 13 +
 rtl/shreg_ld_sh.sv | 35 +++
 rtl/serial_xfer_ctrl.sv | 106 ++++++++++
 tb/tb_serial_xfer_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_xfer_pkg.sv
// Shared encodings for the serial register-to-register transfer controller.
package serial_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_ZERO   = 1'b0;
  localparam logic MODE_ROTATE = 1'b1;

endpackage

// File: rtl/shreg_ld_sh.sv
// WIDTH-bit register with parallel load and MSB-first shift; shift beats load.
module shreg_ld_sh #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_data_i,
  input  logic             sh_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (sh_i) begin
      q_d = {q_q[WIDTH-2:0], sin_i};
    end else if (ld_i) begin
      q_d = ld_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/serial_xfer_ctrl.sv
// Counted, handshaken transfer of the source register into the destination
// register over a 1-bit link, MSB first. state_o exposes the FSM for debug.
module serial_xfer_ctrl
  import serial_xfer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_data_i,
  input  logic             start_i,
  input  logic             rotate_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             sbit_o,
  output logic [WIDTH-1:0] src_q_o,
  output logic [WIDTH-1:0] dst_q_o,
  output state_e           state_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rot_q, rot_d;
  logic          src_ld;
  logic          shift_en;
  logic          fill_bit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rot_d    = rot_q;
    src_ld   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        // start wins over a simultaneous load; the load is dropped
        if (start_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
          rot_d   = rotate_i;
        end else if (ld_i) begin
          src_ld = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        // hold at the last count so the counter never passes WIDTH-1
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rot_q   <= MODE_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
    end
  end

  assign fill_bit = (rot_q == MODE_ROTATE) ? src_q_o[WIDTH-1] : 1'b0;

  shreg_ld_sh #(.WIDTH(WIDTH)) u_src (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ld_i     (src_ld),
    .ld_data_i(ld_data_i),
    .sh_i     (shift_en),
    .sin_i    (fill_bit),
    .q_o      (src_q_o)
  );

  shreg_ld_sh #(.WIDTH(WIDTH)) u_dst (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .ld_i     (1'b0),
    .ld_data_i('0),
    .sh_i     (shift_en),
    .sin_i    (sbit_o),
    .q_o      (dst_q_o)
  );

  assign busy_o  = (state_q == SHIFT);
  assign done_o  = (state_q == DONE);
  assign sbit_o  = src_q_o[WIDTH-1];
  assign state_o = state_q;

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Table-driven, directed and randomized bench for serial_xfer_ctrl (WIDTH=4).
module tb_serial_xfer_ctrl;
  import serial_xfer_pkg::*;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld;
  logic [W-1:0] ld_data;
  logic         start;
  logic         rot;
  logic         busy, done, sbit;
  logic [W-1:0] src_q, dst_q;
  state_e       state;

  serial_xfer_ctrl #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .ld_i     (ld),
    .ld_data_i(ld_data),
    .start_i  (start),
    .rotate_i (rot),
    .busy_o   (busy),
    .done_o   (done),
    .sbit_o   (sbit),
    .src_q_o  (src_q),
    .dst_q_o  (dst_q),
    .state_o  (state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a transfer is described by its start snapshot and the
  // number of edges since the start edge; register values follow arithmetically.
  bit m_active;
  bit m_rot;
  int m_t, m_src, m_dst, m_orig, m_dst0;

  function automatic int shifts_done();
    return (m_t < W) ? m_t : W;
  endfunction

  function automatic int exp_src();
    int s;
    if (!m_active) return m_src;
    s = shifts_done();
    if (m_rot) return ((m_orig << s) | (m_orig >> (W - s))) & MASK;
    return (m_orig << s) & MASK;
  endfunction

  function automatic int exp_dst();
    int s;
    if (!m_active) return m_dst;
    s = shifts_done();
    return ((m_dst0 << s) | (m_orig >> (W - s))) & MASK;
  endfunction

  function automatic int exp_busy();
    return (m_active && m_t < W) ? 1 : 0;
  endfunction

  function automatic int exp_done();
    return (m_active && m_t == W) ? 1 : 0;
  endfunction

  function automatic state_e exp_state();
    if (!m_active) return IDLE;
    return (m_t < W) ? SHIFT : DONE;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_rot    = 1'b0;
    m_t      = 0;
    m_src    = 0;
    m_dst    = 0;
    m_orig   = 0;
    m_dst0   = 0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_active) begin
      if (m_t == W) begin
        m_src    = exp_src();
        m_dst    = exp_dst();
        m_active = 1'b0;
      end else begin
        m_t++;
      end
    end else if (start) begin
      m_active = 1'b1;
      m_t      = 0;
      m_orig   = m_src;
      m_dst0   = m_dst;
      m_rot    = rot;
    end else if (ld) begin
      m_src = int'(ld_data);
    end
  endtask

  task automatic check_model(input string tag);
    int es;
    es = exp_src();
    chk({tag, " busy"},  32'(busy),  32'(exp_busy()));
    chk({tag, " done"},  32'(done),  32'(exp_done()));
    chk({tag, " sbit"},  32'(sbit),  32'((es >> (W - 1)) & 1));
    chk({tag, " src"},   32'(src_q), 32'(es));
    chk({tag, " dst"},   32'(dst_q), 32'(exp_dst()));
    chk({tag, " state"}, 32'(state), 32'(exp_state()));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic l, input logic [W-1:0] d, input logic s, input logic r);
    ld      = l;
    ld_data = d;
    start   = s;
    rot     = r;
  endtask

  typedef struct packed {
    logic         ld;
    logic [W-1:0] data;
    logic         start;
    logic         rot;
    logic         e_busy;
    logic         e_done;
    logic         e_sbit;
    logic [W-1:0] e_src;
    logic [W-1:0] e_dst;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int busy_cnt;
    int done_cnt;
    int last_done;
    int guard;

    // load/start with rotate, then load/start with zero-fill
    tbl[0]  = '{1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111, 4'b0001};
    tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1110, 4'b0010};
    tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1101, 4'b0101};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 4'b1011};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1011, 4'b1011};
    tbl[7]  = '{1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b1011};
    tbl[8]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 4'b1011};
    tbl[9]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1100, 4'b0110};
    tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1000, 4'b1101};
    tbl[11] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1011};
    tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0110};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110};

    // clock/reset
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;

    // reset then idle: load something, then reset asynchronously mid-cycle
    set_in(1'b1, 4'b1010, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, '0, 1'b0, 1'b0);
    check_model("preload");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_model("idle_after_rst");
    end

    // table-driven vectors
    for (int i = 0; i < 14; i++) begin
      set_in(tbl[i].ld, tbl[i].data, tbl[i].start, tbl[i].rot);
      cycle();
      chk($sformatf("tbl%0d busy", i), 32'(busy),  32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d done", i), 32'(done),  32'(tbl[i].e_done));
      chk($sformatf("tbl%0d sbit", i), 32'(sbit),  32'(tbl[i].e_sbit));
      chk($sformatf("tbl%0d src", i),  32'(src_q), 32'(tbl[i].e_src));
      chk($sformatf("tbl%0d dst", i),  32'(dst_q), 32'(tbl[i].e_dst));
    end
    set_in(1'b0, '0, 1'b0, 1'b0);

    // load and start together: start wins, transfer uses previous src
    set_in(1'b1, 4'b1001, 1'b0, 1'b0);
    cycle();
    check_model("coll_pre");
    set_in(1'b1, 4'b1111, 1'b1, 1'b0);
    cycle();
    set_in(1'b0, '0, 1'b0, 1'b0);
    check_model("coll_start");
    guard = 0;
    while (!done && guard < 20) begin
      cycle();
      check_model("coll_run");
      guard++;
    end
    chk("coll_done_seen", 32'(done), 32'd1);
    chk("coll_dst", 32'(dst_q), 32'b1001);
    chk("coll_src", 32'(src_q), 32'b0000);

    // requests during SHIFT/DONE are ignored; still exactly W shifts
    cycle();
    set_in(1'b1, 4'b0101, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, '0, 1'b1, 1'b1);
    cycle();
    busy_cnt = 0;
    guard    = 0;
    while (!done && guard < 20) begin
      if (busy) busy_cnt++;
      set_in(guard[0], 4'b1111, ~guard[0], 1'b0);
      cycle();
      check_model("ign_run");
      guard++;
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    chk("ign_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("ign_dst", 32'(dst_q), 32'b0101);
    chk("ign_src", 32'(src_q), 32'b0101);
    cycle();
    check_model("ign_idle");

    // reset after the second shift abandons the transfer
    set_in(1'b1, 4'b1110, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, '0, 1'b1, 1'b1);
    cycle();
    set_in(1'b0, '0, 1'b0, 1'b0);
    cycle();
    cycle();
    check_model("mid_two_shifts");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("mid_rst");
    cycle();
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      cycle();
      check_model("post_mid_rst");
    end

    // back-to-back: start held high
    set_in(1'b1, 4'b1100, 1'b0, 1'b0);
    cycle();
    set_in(1'b0, '0, 1'b1, 1'b1);
    done_cnt  = 0;
    last_done = -1;
    for (int i = 0; i < 3 * (W + 2); i++) begin
      cycle();
      check_model("b2b");
      if (done) begin
        if (last_done >= 0) chk("b2b_spacing", 32'(i - last_done), 32'(W + 2));
        last_done = i;
        done_cnt++;
      end
    end
    chk("b2b_done_count", 32'(done_cnt), 32'd3);
    set_in(1'b0, '0, 1'b0, 1'b0);

    // randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 2) == 0), W'($urandom_range(0, MASK)),
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rnd_rst");
        cycle();
        rst = 1'b0;
      end else begin
        cycle();
        check_model("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
